// File: rtl/mem_arb_pkg.sv
// Shared state encoding, requester IDs and counter width for the memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// MEM_ARB_DATA_PRIO_EN: data wins every tie and the last-grant input is absent.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
`ifndef MEM_ARB_DATA_PRIO_EN
   input  logic last_gnt,
`endif
   output logic gnt_vld,
   output logic gnt_id
);

   always_comb begin
      gnt_vld = i_req | d_req;
      gnt_id  = REQ_I;
      if (i_req && d_req) begin
`ifdef MEM_ARB_DATA_PRIO_EN
         gnt_id = REQ_D;
`else
         // Round-robin: the side that did not win last time takes the tie.
         gnt_id = (last_gnt == REQ_D) ? REQ_I : REQ_D;
`endif
      end else if (d_req) begin
         gnt_id = REQ_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter, one transaction in flight,
// done at MEM_LAT+2 cycles after the request is seen; MEM_ARB_DATA_PRIO_EN selects fixed data priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int AW      = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_done,
   output logic [31:0]   i_rdata,
   input  logic          d_req,
   input  logic [AW-1:0] d_addr,
   input  logic [3:0]    d_we,
   input  logic [31:0]   d_wdata,
   output logic          d_done,
   output logic [31:0]   d_rdata,
   output logic          m_en,
   output logic [AW-1:0] m_addr,
   output logic [3:0]    m_we,
   output logic [31:0]   m_wdata,
   input  logic [31:0]   m_rdata,
   output logic          busy
);

   localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             id_q, id_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [3:0]       we_q, we_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             gnt_vld, gnt_id;
`ifndef MEM_ARB_DATA_PRIO_EN
   logic             last_q, last_d;
`endif

   mem_arb_pick u_pick (
      .i_req    (i_req),
      .d_req    (d_req),
`ifndef MEM_ARB_DATA_PRIO_EN
      .last_gnt (last_q),
`endif
      .gnt_vld  (gnt_vld),
      .gnt_id   (gnt_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         id_q    <= REQ_I;
         addr_q  <= '0;
         we_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifndef MEM_ARB_DATA_PRIO_EN
         last_q  <= REQ_D;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifndef MEM_ARB_DATA_PRIO_EN
         last_q  <= last_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifndef MEM_ARB_DATA_PRIO_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               state_d = ISSUE;
               id_d    = gnt_id;
               addr_d  = (gnt_id == REQ_D) ? d_addr : i_addr;
               we_d    = (gnt_id == REQ_D) ? d_we : 4'b0000;
               wdata_d = (gnt_id == REQ_D) ? d_wdata : 32'h0;
`ifndef MEM_ARB_DATA_PRIO_EN
               last_d  = gnt_id;
`endif
            end
         end
         ISSUE: begin
            cnt_d   = LAT_CNT;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               // Writes return zero data, so only reads capture the bus.
               rdata_d = (we_q == 4'b0000) ? m_rdata : 32'h0;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign m_en    = (state_q == ISSUE);
   assign m_addr  = m_en ? addr_q : '0;
   assign m_we    = m_en ? we_q : 4'b0000;
   assign m_wdata = m_en ? wdata_q : 32'h0;

   assign i_done  = (state_q == RESP) && (id_q == REQ_I);
   assign d_done  = (state_q == RESP) && (id_q == REQ_D);
   assign i_rdata = i_done ? rdata_q : 32'h0;
   assign d_rdata = d_done ? rdata_q : 32'h0;

   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) with a latency-accurate memory model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
`ifdef MEM_ARB_DATA_PRIO_EN
   localparam bit DPRIO = 1'b1;
`else
   localparam bit DPRIO = 1'b0;
`endif
   localparam logic TIE_FIRST = DPRIO ? REQ_D : REQ_I;

   logic clk, rst;
   logic          i_req   [2];
   logic [AW-1:0] i_addr  [2];
   logic          i_done  [2];
   logic [31:0]   i_rdata [2];
   logic          d_req   [2];
   logic [AW-1:0] d_addr  [2];
   logic [3:0]    d_we    [2];
   logic [31:0]   d_wdata [2];
   logic          d_done  [2];
   logic [31:0]   d_rdata [2];
   logic          m_en    [2];
   logic [AW-1:0] m_addr  [2];
   logic [3:0]    m_we    [2];
   logic [31:0]   m_wdata [2];
   logic [31:0]   m_rdata [2];
   logic          busy    [2];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   mem_arbiter #(.MEM_LAT(1), .AW(AW)) u_dut_l1 (
      .clk(clk), .rst(rst),
      .i_req(i_req[0]), .i_addr(i_addr[0]), .i_done(i_done[0]), .i_rdata(i_rdata[0]),
      .d_req(d_req[0]), .d_addr(d_addr[0]), .d_we(d_we[0]), .d_wdata(d_wdata[0]),
      .d_done(d_done[0]), .d_rdata(d_rdata[0]),
      .m_en(m_en[0]), .m_addr(m_addr[0]), .m_we(m_we[0]), .m_wdata(m_wdata[0]),
      .m_rdata(m_rdata[0]), .busy(busy[0])
   );

   mem_arbiter #(.MEM_LAT(3), .AW(AW)) u_dut_l3 (
      .clk(clk), .rst(rst),
      .i_req(i_req[1]), .i_addr(i_addr[1]), .i_done(i_done[1]), .i_rdata(i_rdata[1]),
      .d_req(d_req[1]), .d_addr(d_addr[1]), .d_we(d_we[1]), .d_wdata(d_wdata[1]),
      .d_done(d_done[1]), .d_rdata(d_rdata[1]),
      .m_en(m_en[1]), .m_addr(m_addr[1]), .m_we(m_we[1]), .m_wdata(m_wdata[1]),
      .m_rdata(m_rdata[1]), .busy(busy[1])
   );

   function automatic int lat(int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] mem_word(logic [AW-1:0] a);
      if (a == 32'h100) return 32'hDEAD_BEEF;
      return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
   endfunction

   // Memory: read data is valid only in the single cycle MEM_LAT after m_en; junk otherwise.
   for (genvar k = 0; k < 2; k++) begin : g_mem
      localparam int L = (k == 0) ? 1 : 3;
      logic [15:0]   pv;
      logic [AW-1:0] pa [16];
      always @(posedge clk or posedge rst) begin
         if (rst) begin
            pv <= '0;
         end else begin
            pv    <= {pv[14:0], m_en[k] && (m_we[k] == 4'b0000)};
            pa[0] <= m_addr[k];
            for (int j = 1; j < 16; j++) pa[j] <= pa[j-1];
         end
      end
      assign m_rdata[k] = pv[L-1] ? mem_word(pa[L-1]) : (32'hA5A5_0000 ^ 32'(cyc));
   end

   function automatic logic [135:0] obs(int k);
      return {m_en[k], m_addr[k], m_we[k], m_wdata[k], i_done[k], i_rdata[k],
              d_done[k], d_rdata[k], busy[k]};
   endfunction

   task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      for (int k = 0; k < 2; k++) begin
         i_req[k] = 1'b0; i_addr[k] = '0;
         d_req[k] = 1'b0; d_addr[k] = '0; d_we[k] = 4'b0; d_wdata[k] = 32'h0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      int          k;
      logic        ireq;
      logic        dreq;
      logic [31:0] iaddr;
      logic [31:0] daddr;
      logic [3:0]  we;
      logic [31:0] wdata;
      int          e_men;
      logic [31:0] e_maddr;
      logic [3:0]  e_mwe;
      logic [31:0] e_mwdata;
      int          e_done;
      logic        e_id;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs [6];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      rst = 1'b1;
      clear_inputs();

      vecs[0] = '{0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'h0,
                  1, 32'h100, 4'h0, 32'h0, 3, REQ_I, 32'hDEAD_BEEF};
      vecs[1] = '{1, 1'b0, 1'b1, 32'h0, 32'h40, 4'b0011, 32'h0000_ABCD,
                  1, 32'h40, 4'b0011, 32'h0000_ABCD, 5, REQ_D, 32'h0};
      vecs[2] = '{1, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h0,
                  1, 32'h200, 4'h0, 32'h0, 5, REQ_I, mem_word(32'h200)};
      vecs[3] = '{0, 1'b1, 1'b1, 32'h104, 32'h80, 4'h0, 32'h0,
                  1, DPRIO ? 32'h80 : 32'h104, 4'h0, 32'h0, 3, TIE_FIRST,
                  DPRIO ? mem_word(32'h80) : mem_word(32'h104)};
      vecs[4] = '{0, 1'b0, 1'b1, 32'h0, 32'h100, 4'h0, 32'h0,
                  1, 32'h100, 4'h0, 32'h0, 3, REQ_D, 32'hDEAD_BEEF};
      vecs[5] = '{1, 1'b1, 1'b1, 32'h300, 32'h44, 4'hF, 32'h1122_3344,
                  1, DPRIO ? 32'h44 : 32'h300, DPRIO ? 4'hF : 4'h0,
                  DPRIO ? 32'h1122_3344 : 32'h0, 5, TIE_FIRST,
                  DPRIO ? 32'h0 : mem_word(32'h300)};

      // Reset state of both instances
      repeat (2) @(negedge clk);
      check("reset outputs l1", obs(0), '0);
      check("reset outputs l3", obs(1), '0);

      // Single-transaction vectors
      for (int v = 0; v < 6; v++) begin
         int k, men_cyc, men_cnt, done_cyc;
         logic [31:0] maddr, mwdata, rdata;
         logic [3:0]  mwe;
         logic        did;
         k = vecs[v].k;
         do_reset();
         i_req[k] = vecs[v].ireq;  i_addr[k] = vecs[v].iaddr;
         d_req[k] = vecs[v].dreq;  d_addr[k] = vecs[v].daddr;
         d_we[k]  = vecs[v].we;    d_wdata[k] = vecs[v].wdata;
         men_cyc = -1; men_cnt = 0; done_cyc = -1;
         maddr = 'x; mwdata = 'x; rdata = 'x; mwe = 'x; did = 1'bx;
         for (int t = 0; t < 12 && done_cyc < 0; t++) begin
            @(negedge clk);
            if (m_en[k]) begin
               men_cnt++;
               if (men_cyc < 0) begin
                  men_cyc = cyc; maddr = m_addr[k]; mwe = m_we[k]; mwdata = m_wdata[k];
               end
            end
            if (i_done[k] || d_done[k]) begin
               done_cyc = cyc;
               did      = d_done[k];
               rdata    = d_done[k] ? d_rdata[k] : i_rdata[k];
               i_req[k] = 1'b0;
               d_req[k] = 1'b0;
            end
         end
         check($sformatf("v%0d m_en cycle", v), 136'(men_cyc), 136'(vecs[v].e_men));
         check($sformatf("v%0d m_en count", v), 136'(men_cnt), 136'(1));
         check($sformatf("v%0d m_addr", v), 136'(maddr), 136'(vecs[v].e_maddr));
         check($sformatf("v%0d m_we", v), 136'(mwe), 136'(vecs[v].e_mwe));
         check($sformatf("v%0d m_wdata", v), 136'(mwdata), 136'(vecs[v].e_mwdata));
         check($sformatf("v%0d done cycle", v), 136'(done_cyc), 136'(vecs[v].e_done));
         check($sformatf("v%0d done id", v), 136'(did), 136'(vecs[v].e_id));
         check($sformatf("v%0d rdata", v), 136'(rdata), 136'(vecs[v].e_rdata));
      end

      // Both requests held from reset: grant order and spacing
      begin
         int n;
         int dcyc [4];
         logic ids [4];
         do_reset();
         i_req[0] = 1'b1; i_addr[0] = 32'h10;
         d_req[0] = 1'b1; d_addr[0] = 32'h20;
         n = 0;
         for (int j = 0; j < 4; j++) begin dcyc[j] = -1; ids[j] = 1'bx; end
         for (int t = 0; t < 40 && n < 4; t++) begin
            @(negedge clk);
            if (i_done[0] || d_done[0]) begin
               ids[n] = d_done[0]; dcyc[n] = cyc; n++;
            end
         end
         for (int j = 0; j < 4; j++) begin
            check($sformatf("tie grant %0d id", j), 136'(ids[j]),
                  136'(DPRIO ? REQ_D : ((j % 2 == 0) ? REQ_I : REQ_D)));
            check($sformatf("tie grant %0d cycle", j), 136'(dcyc[j]), 136'(3 + 4 * j));
         end
         clear_inputs();
      end

      // Reset during WAIT discards the transaction
      begin
         int evts, start, done_cyc;
         logic [31:0] rdata;
         do_reset();
         i_req[1] = 1'b1; i_addr[1] = 32'h180;
         repeat (3) @(negedge clk);
         check("abort busy before rst", 136'(busy[1]), 136'(1));
         rst = 1'b1;
         #1;
         check("abort outputs in rst", obs(1), '0);
         i_req[1] = 1'b0;
         @(negedge clk);
         rst = 1'b0;
         evts = 0;
         for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (i_done[1] || d_done[1] || m_en[1] || busy[1]) evts++;
         end
         check("abort no activity", 136'(evts), 136'(0));
         start = cyc; done_cyc = -1; rdata = 'x;
         d_req[1] = 1'b1; d_addr[1] = 32'h100; d_we[1] = 4'b0;
         for (int t = 0; t < 12 && done_cyc < 0; t++) begin
            @(negedge clk);
            if (d_done[1]) begin done_cyc = cyc; rdata = d_rdata[1]; d_req[1] = 1'b0; end
         end
         check("after abort done latency", 136'(done_cyc - start), 136'(5));
         check("after abort rdata", 136'(rdata), 136'(32'hDEAD_BEEF));
      end

      // Fetch request dropped during WAIT still completes once
      begin
         int done_cnt, men_cnt, done_cyc;
         logic [31:0] rdata;
         do_reset();
         i_req[1] = 1'b1; i_addr[1] = 32'h1C0;
         done_cnt = 0; men_cnt = 0; done_cyc = -1; rdata = 'x;
         for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (cyc == 3) i_req[1] = 1'b0;
            if (m_en[1]) men_cnt++;
            if (i_done[1]) begin done_cnt++; done_cyc = cyc; rdata = i_rdata[1]; end
         end
         check("drop done count", 136'(done_cnt), 136'(1));
         check("drop done cycle", 136'(done_cyc), 136'(5));
         check("drop m_en count", 136'(men_cnt), 136'(1));
         check("drop rdata", 136'(rdata), 136'(mem_word(32'h1C0)));
      end

      // Random traffic against a transaction-timing reference model
      for (int k = 0; k < 2; k++) begin
         int g, L;
         logic pend_i, pend_d, last_d, win, e_men, e_done, e_idn, e_ddn, jd_i, jd_d;
         logic [31:0] ia, da, wd, c_addr, c_wdata, c_rdata;
         logic [3:0]  dwe, c_we;
         logic        c_id;
         logic [135:0] exp;
         do_reset();
         L = lat(k); g = -100; last_d = 1'b1;
         pend_i = 1'b0; pend_d = 1'b0; c_id = REQ_I;
         ia = '0; da = '0; wd = '0; dwe = '0;
         c_addr = '0; c_wdata = '0; c_rdata = '0; c_we = '0;
         for (int t = 0; t < 400; t++) begin
            if (t > 0) @(negedge clk);
            e_men  = (t == g + 1);
            e_done = (t == g + L + 2);
            e_idn  = e_done && (c_id == REQ_I);
            e_ddn  = e_done && (c_id == REQ_D);
            exp = {e_men, e_men ? c_addr : 32'h0, e_men ? c_we : 4'h0, e_men ? c_wdata : 32'h0,
                   e_idn, e_idn ? c_rdata : 32'h0, e_ddn, e_ddn ? c_rdata : 32'h0,
                   (t >= g + 1) && (t <= g + L + 2)};
            check($sformatf("rand k%0d t%0d", k, t), obs(k), exp);
            jd_i = e_idn; jd_d = e_ddn;
            if (jd_i) pend_i = 1'b0;
            if (jd_d) pend_d = 1'b0;
            if (!pend_i && !jd_i && $urandom_range(2) == 0) begin
               pend_i = 1'b1; ia = $urandom & 32'hFFFF_FFFC;
            end
            if (!pend_d && !jd_d && $urandom_range(2) == 0) begin
               pend_d = 1'b1; da = $urandom & 32'hFFFF_FFFC; wd = $urandom;
               dwe = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
            end
            i_req[k] = pend_i; i_addr[k] = ia;
            d_req[k] = pend_d; d_addr[k] = da; d_we[k] = dwe; d_wdata[k] = wd;
            if (t >= g + L + 3 && (pend_i || pend_d)) begin
               if (pend_i && pend_d) win = DPRIO ? REQ_D : (last_d ? REQ_I : REQ_D);
               else                  win = pend_d ? REQ_D : REQ_I;
               last_d  = win;
               g       = t;
               c_id    = win;
               c_addr  = win ? da : ia;
               c_we    = win ? dwe : 4'h0;
               c_wdata = win ? wd : 32'h0;
               c_rdata = (c_we == 4'h0) ? mem_word(c_addr) : 32'h0;
            end
         end
         clear_inputs();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
